div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle 32-bit signed/unsigned divider for the EX stage (DIV/DIVU).
//  Restoring division at one quotient bit per cycle.
//  While busy it raises stop_req_o. EX forwards this as StopReq_from_ex to the
//  pipeline controller, which freezes PC/IF/ID/EX (stop = 6'b001111).
//  Result goes to HI/LO via EX: hi = remainder, lo = quotient.
// PARAMETERS
//  WIDTH   32   operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk          in   1        clock; all state changes on the rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  start_i      in   1        EX requests a divide; held high until the cycle ready_o is seen
//  annul_i      in   1        abort the current operation (flush)
//  signed_i     in   1        1 = DIV (two's complement), 0 = DIVU
//  dividend_i   in   WIDTH    operand rs
//  divisor_i    in   WIDTH    operand rt
//  result_o     out  2*WIDTH  {remainder, quotient}
//  ready_o      out  1        result_o valid
//  stop_req_o   out  1        `Stop while start_i && !ready_o, else `NoStop
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE, cnt=0, result_o=0, ready_o=0, internal regs=0.
//   - Reset mid-operation abandons the divide immediately.
//  States: IDLE, BYZERO, ON, END (2-bit encoding).
//  IDLE
//   - start_i && !annul_i && divisor_i==0 -> BYZERO.
//   - start_i && !annul_i, divisor nonzero -> ON, cnt=0.
//   - On entry to ON, latch |dividend| and |divisor| (when signed_i), and the
//     sign flags sq = sign(dvd)^sign(dvs) and sr = sign(dvd).
//   - Otherwise stay in IDLE.
//  BYZERO
//   - Next cycle -> END with result_o = 0.
//  ON (one iteration per cycle)
//   - partial = {rem, quo} << 1; diff = partial[2W-1:W] - dvs (W+1 bits).
//   - If diff >= 0: rem = diff[W-1:0], quo[0] = 1. Else: rem = partial hi, quo[0] = 0.
//   - cnt increments each cycle.
//   - After the iteration with cnt == WIDTH-1 -> END.
//   - Result on entry to END: quotient negated if signed_i && sq; remainder
//     negated if signed_i && sr.
//  END
//   - ready_o = 1; result_o is held.
//   - start_i == 0 -> IDLE next cycle (ready_o drops, result_o cleared to 0).
//   - start_i == 1 -> stay in END.
//  Latency
//   - start_i sampled in IDLE at cycle N; ready_o high from N+WIDTH+1 (N+33).
//   - Divisor == 0: ready_o high from N+2.
//  Stall request
//   - stop_req_o is combinational: start_i && !ready_o && !annul_i.
//   - It is therefore low in the END cycle, so EX advances that cycle.
//  annul_i
//   - High in any state -> IDLE next cycle, ready_o=0, no result.
//   - annul_i has priority over start_i.
//  Width and overflow
//   - Magnitudes are taken modulo 2^W, so 0x80000000 passes through unchanged.
//   - DIV 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0 (MIPS leaves this
//     UNPREDICTABLE; this block fixes it).
//  Operand changes
//   - Changes on dividend_i/divisor_i after the start cycle are ignored.
//     Operands are latched on entry to ON.
// STRUCTURE
//  - define.v gains state constants: `DivFree, `DivByZero, `DivOn, `DivEnd.
//  - Reuse the existing `Stop/`NoStop constants from define.v.
//  - Single module, no sub-module. The optional negate helper stays inline.
//  - The EX stage ORs stop_req_o into its StopReq_from_ex output.
// TESTING
//  1. DIVU 100/7, start at N -> ready_o at N+33; result_o = {32'd2, 32'd14};
//     stop_req_o high N..N+32.
//  2. DIV -7/2 (0xFFFFFFF9 / 0x2) -> q = 0xFFFFFFFD, r = 0xFFFFFFFF.
//     DIV 7/-2 -> q = 0xFFFFFFFD, r = 1.
//  3. DIV 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0.
//     DIVU 0xFFFFFFFF / 1 -> q = 0xFFFFFFFF, r = 0.
//  4. Divisor 0 -> ready_o at N+2, result_o = 0; stop_req_o high only N..N+1.
//  5. annul_i pulsed at N+10 -> state IDLE at N+11, ready_o never rises,
//     stop_req_o low.
//     New start at N+12 -> correct result at N+45.
//  6. rst_n low at N+5 (asynchronous, between edges) -> outputs 0 at once.
//     start_i held high after release -> full 33-cycle divide restarts.
//     Also hold start_i 3 cycles in END -> result_o stable; IDLE after start_i drops.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StByZero = 2'b01,
    StOn     = 2'b10,
    StEnd    = 2'b11
  } div_state_e;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake and operand/result bundle.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [WIDTH-1:0]   dividend_i;
  logic [WIDTH-1:0]   divisor_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stop_req_o;

  modport master (
    output start_i, annul_i, signed_i, dividend_i, divisor_i,
    input  result_o, ready_o, stop_req_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, dividend_i, divisor_i,
    output result_o, ready_o, stop_req_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring signed/unsigned divider, one quotient bit per cycle; result = {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  div_unit_if.slave div_io
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;

  div_state_e         state_q;
  logic [CntW-1:0]    cnt_q;
  word_t              rem_q, quo_q, dvs_q;
  logic               sq_q, sr_q;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;

  word_t              dvd_abs, dvs_abs;
  logic               dvd_neg, dvs_neg;
  logic [2*WIDTH:0]   partial;
  logic [WIDTH:0]     diff;
  word_t              rem_d, quo_d, rem_fin, quo_fin;

  // Magnitudes wrap modulo 2^WIDTH, so the most negative value maps to itself.
  assign dvd_neg = div_io.signed_i & div_io.dividend_i[WIDTH-1];
  assign dvs_neg = div_io.signed_i & div_io.divisor_i[WIDTH-1];
  assign dvd_abs = dvd_neg ? word_t'(-div_io.dividend_i) : div_io.dividend_i;
  assign dvs_abs = dvs_neg ? word_t'(-div_io.divisor_i) : div_io.divisor_i;

  // Extra carry bit keeps the shifted remainder exact when it exceeds 2^(WIDTH-1).
  always_comb begin
    partial = {1'b0, rem_q, quo_q} << 1;
    diff    = partial[2*WIDTH:WIDTH] - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {partial[WIDTH-1:1], 1'b1};
    end else begin
      rem_d = partial[2*WIDTH-1:WIDTH];
      quo_d = partial[WIDTH-1:0];
    end
    quo_fin = sq_q ? word_t'(-quo_d) : quo_d;
    rem_fin = sr_q ? word_t'(-rem_d) : rem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else if (div_io.annul_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (div_io.start_i) begin
            if (div_io.divisor_i == '0) begin
              state_q <= StByZero;
            end else begin
              state_q <= StOn;
              cnt_q   <= '0;
              rem_q   <= '0;
              quo_q   <= dvd_abs;
              dvs_q   <= dvs_abs;
              sq_q    <= dvd_neg ^ dvs_neg;
              sr_q    <= dvd_neg;
            end
          end
        end
        StByZero: begin
          state_q  <= StEnd;
          ready_q  <= 1'b1;
          result_q <= '0;
        end
        StOn: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q  <= StEnd;
            ready_q  <= 1'b1;
            result_q <= {rem_fin, quo_fin};
          end
        end
        StEnd: begin
          if (!div_io.start_i) begin
            state_q  <= StIdle;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign div_io.result_o   = result_q;
  assign div_io.ready_o    = ready_q;
  assign div_io.stop_req_o = (div_io.start_i && !ready_q && !div_io.annul_i) ? Stop : NoStop;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, div-by-zero, annul, reset.
module tb_div_unit;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  div_unit_if #(.WIDTH(32)) div_if ();

  div_unit #(.WIDTH(32)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_io (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a divide at the next negedge (cycle N) and wait for ready_o, leaving start_i high.
  // lat = cycles from N to first ready_o, or -1 on timeout. Operands are scrambled after N.
  task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn,
                        output int lat, output bit stop_ok, output logic [63:0] res);
    @(negedge clk);
    div_if.start_i    = 1'b1;
    div_if.signed_i   = sgn;
    div_if.dividend_i = dvd;
    div_if.divisor_i  = dvs;
    #1;
    stop_ok = (div_if.stop_req_o === 1'b1);
    lat     = -1;
    res     = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        div_if.dividend_i = ~dvd;
        div_if.divisor_i  = 32'h0;
        div_if.signed_i   = ~sgn;
      end
      #1;
      if (div_if.ready_o === 1'b1) begin
        lat = k;
        res = div_if.result_o;
        if (div_if.stop_req_o !== 1'b0) stop_ok = 0;
        break;
      end
      if (div_if.stop_req_o !== 1'b1) stop_ok = 0;
    end
  endtask

  // Drop start_i in END; the next cycle must be IDLE with cleared outputs.
  task automatic release_op(input string name);
    @(negedge clk);
    div_if.start_i = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (div_if.ready_o !== 1'b0 || div_if.result_o !== 64'h0)
      $display("FAIL %s_release: ready=%b result=%h, required ready=0 result=0",
               name, div_if.ready_o, div_if.result_o);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    div_if.start_i = 0; div_if.annul_i = 0; div_if.signed_i = 0;
    div_if.dividend_i = 0; div_if.divisor_i = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (div_if.ready_o !== 1'b0 || div_if.result_o !== 64'h0 || div_if.stop_req_o !== 1'b0)
      $display("FAIL reset_state: ready=%b result=%h stop=%b, required 0/0/0",
               div_if.ready_o, div_if.result_o, div_if.stop_req_o);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_divu_basic();
    int lat; bit stop_ok; logic [63:0] res;
    run_op(32'd100, 32'd7, 1'b0, lat, stop_ok, res);
    total_cnt++;
    if (lat !== 33) $display("FAIL divu_latency: got %0d, required 33", lat);
    else pass_cnt++;
    total_cnt++;
    if (res !== {32'd2, 32'd14}) $display("FAIL divu_result: got %h, required %h",
                                          res, {32'd2, 32'd14});
    else pass_cnt++;
    total_cnt++;
    if (!stop_ok) $display("FAIL divu_stop_req: got bad pattern, required high N..N+32 only");
    else pass_cnt++;
    release_op("divu");
  endtask

  task automatic test_signed();
    int lat; bit stop_ok; logic [63:0] res;
    run_op(32'hFFFFFFF9, 32'h2, 1'b1, lat, stop_ok, res);
    total_cnt++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD} || lat !== 33)
      $display("FAIL div_neg7_2: got %h lat %0d, required ffffffff_fffffffd lat 33", res, lat);
    else pass_cnt++;
    release_op("div_neg7_2");
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, lat, stop_ok, res);
    total_cnt++;
    if (res !== {32'h1, 32'hFFFFFFFD})
      $display("FAIL div_7_neg2: got %h, required 00000001_fffffffd", res);
    else pass_cnt++;
    release_op("div_7_neg2");
  endtask

  task automatic test_boundary();
    int lat; bit stop_ok; logic [63:0] res;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, stop_ok, res);
    total_cnt++;
    if (res !== {32'h0, 32'h80000000})
      $display("FAIL div_overflow: got %h, required 00000000_80000000", res);
    else pass_cnt++;
    release_op("div_overflow");
    run_op(32'hFFFFFFFF, 32'h1, 1'b0, lat, stop_ok, res);
    total_cnt++;
    if (res !== {32'h0, 32'hFFFFFFFF})
      $display("FAIL divu_max_1: got %h, required 00000000_ffffffff", res);
    else pass_cnt++;
    release_op("divu_max_1");
    run_op(32'hFFFFFFFF, 32'h80000001, 1'b0, lat, stop_ok, res);
    total_cnt++;
    if (res !== {32'h7FFFFFFE, 32'h1})
      $display("FAIL divu_big_divisor: got %h, required 7ffffffe_00000001", res);
    else pass_cnt++;
    release_op("divu_big_divisor");
  endtask

  task automatic test_div_by_zero();
    int lat; bit stop_ok; logic [63:0] res;
    run_op(32'd1234, 32'd0, 1'b1, lat, stop_ok, res);
    total_cnt++;
    if (lat !== 2) $display("FAIL byzero_latency: got %0d, required 2", lat);
    else pass_cnt++;
    total_cnt++;
    if (res !== 64'h0) $display("FAIL byzero_result: got %h, required 0", res);
    else pass_cnt++;
    total_cnt++;
    if (!stop_ok) $display("FAIL byzero_stop_req: got bad pattern, required high N..N+1 only");
    else pass_cnt++;
    release_op("byzero");
  endtask

  task automatic test_annul();
    int lat; bit stop_ok; logic [63:0] res;
    @(negedge clk);
    div_if.start_i = 1'b1; div_if.signed_i = 1'b0;
    div_if.dividend_i = 32'd500; div_if.divisor_i = 32'd3;
    repeat (10) @(negedge clk);
    div_if.annul_i = 1'b1;
    #1;
    total_cnt++;
    if (div_if.stop_req_o !== 1'b0 || div_if.ready_o !== 1'b0)
      $display("FAIL annul_stop_req: stop=%b ready=%b, required 0/0",
               div_if.stop_req_o, div_if.ready_o);
    else pass_cnt++;
    @(negedge clk);
    div_if.annul_i = 1'b0;
    div_if.start_i = 1'b0;
    #1;
    total_cnt++;
    if (div_if.ready_o !== 1'b0 || div_if.stop_req_o !== 1'b0 || div_if.result_o !== 64'h0)
      $display("FAIL annul_idle: ready=%b stop=%b result=%h, required 0/0/0",
               div_if.ready_o, div_if.stop_req_o, div_if.result_o);
    else pass_cnt++;
    run_op(32'd500, 32'd3, 1'b0, lat, stop_ok, res);
    total_cnt++;
    if (lat !== 33 || res !== {32'd2, 32'd166})
      $display("FAIL annul_restart: got %h lat %0d, required 00000002_000000a6 lat 33",
               res, lat);
    else pass_cnt++;
    release_op("annul_restart");
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [63:0] held;
    bit stable;
    @(negedge clk);
    div_if.start_i = 1'b1; div_if.signed_i = 1'b0;
    div_if.dividend_i = 32'd1000; div_if.divisor_i = 32'd10;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (div_if.ready_o !== 1'b0 || div_if.result_o !== 64'h0)
      $display("FAIL reset_mid_op: ready=%b result=%h, required 0/0",
               div_if.ready_o, div_if.result_o);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      #1;
      if (div_if.ready_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    total_cnt++;
    if (lat !== 33 || div_if.result_o !== {32'd0, 32'd100})
      $display("FAIL reset_restart: got %h lat %0d, required 00000000_00000064 lat 33",
               div_if.result_o, lat);
    else pass_cnt++;
    held   = div_if.result_o;
    stable = 1;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (div_if.ready_o !== 1'b1 || div_if.result_o !== {32'd0, 32'd100}) stable = 0;
    end
    total_cnt++;
    if (!stable)
      $display("FAIL end_hold: ready=%b result=%h, required 1 and %h held",
               div_if.ready_o, div_if.result_o, held);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (div_if.ready_o !== 1'b0 || div_if.result_o !== 64'h0)
      $display("FAIL reset_in_end: ready=%b result=%h, required 0/0",
               div_if.ready_o, div_if.result_o);
    else pass_cnt++;
    @(negedge clk);
    div_if.start_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_hold_then_release();
    int lat; bit stop_ok; logic [63:0] res;
    run_op(32'd81, 32'd9, 1'b1, lat, stop_ok, res);
    total_cnt++;
    if (res !== {32'd0, 32'd9}) $display("FAIL div_81_9: got %h, required 00000000_00000009", res);
    else pass_cnt++;
    release_op("div_81_9");
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_boundary();
    test_div_by_zero();
    test_annul();
    test_reset_mid();
    test_hold_then_release();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
